// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and registered read data.
// Define FIFO_ERR_FLAGS_EN to enable the sticky overflow/underflow flags (tied low otherwise).
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 5,
    parameter int AF_THRESH = 28,
    parameter int AE_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              w_en,
    input  logic              r_en,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AF_LVL  = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_LVL  = (ADDR_W+1)'(AE_THRESH);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   w_ptr_reg;
    logic [ADDR_W:0]   r_ptr_reg;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] r_addr;
    logic              rd_acc;
    logic              wr_acc;

    assign w_addr = w_ptr_reg[ADDR_W-1:0];
    assign r_addr = r_ptr_reg[ADDR_W-1:0];

    // The extra MSB on each pointer distinguishes full from empty when the indices match.
    assign empty        = (w_ptr_reg == r_ptr_reg);
    assign full         = (w_ptr_reg[ADDR_W] != r_ptr_reg[ADDR_W]) && (w_addr == r_addr);
    assign count        = w_ptr_reg - r_ptr_reg;
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    assign rd_acc = r_en & ~empty;
    assign wr_acc = w_en & (~full | rd_acc);

    // Storage carries no reset; on a full-FIFO read+write the read sees the old entry.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[w_addr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_ptr_reg <= '0;
            r_ptr_reg <= '0;
            data_out  <= '0;
            rd_valid  <= 1'b0;
        end else begin
            if (wr_acc) begin
                w_ptr_reg <= w_ptr_reg + PTR_ONE;
            end
            if (rd_acc) begin
                r_ptr_reg <= r_ptr_reg + PTR_ONE;
                data_out  <= mem[r_addr];
            end
            rd_valid <= rd_acc;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_reg;
    logic underflow_reg;

    // A new error in the same cycle takes priority over the clear request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (w_en & ~wr_acc) begin
                overflow_reg <= 1'b1;
            end else if (err_clr) begin
                overflow_reg <= 1'b0;
            end
            if (r_en & ~rd_acc) begin
                underflow_reg <= 1'b1;
            end else if (err_clr) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO: the next-generation single-clock buffer for byte and word streams between producer and consumer blocks on the same clock. Generalises the fixed 8×32 queue to configurable width and depth. Adds an occupancy count, programmable almost-full/almost-empty flags, a read-valid strobe, write-through-full when a read happens in the same cycle, and optional sticky overflow/underflow error flags.

## Interface
- DATA_W, 8: data width in bits, ≥1.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W (default 32), ADDR_W ≥ 1.
- AF_THRESH, 28: almost_full asserts when count ≥ AF_THRESH; range 1..DEPTH.
- AE_THRESH, 4: almost_empty asserts when count ≤ AE_THRESH; range 0..DEPTH-1.

- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  DATA_W  write data.
- w_en  in  1  write request.
- r_en  in  1  read request.
- err_clr  in  1  clears sticky error flags.
- data_out  out  DATA_W  registered read data.
- rd_valid  out  1  data_out was loaded by the read accepted in the previous cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was refused.
- underflow  out  1  sticky: a read was refused.

## Operation
- Storage: DEPTH × DATA_W array, not reset. Write and read pointers are ADDR_W+1 bits: the low ADDR_W bits index the array, and the MSB is the wrap bit.
- empty = (w_ptr == r_ptr). full = wrap bits differ and the low bits are equal. count = w_ptr − r_ptr, taken modulo 2**(ADDR_W+1).
- rd_acc = r_en & ~empty.
- wr_acc = w_en & (~full | rd_acc). A write to a full FIFO succeeds if a read is accepted in the same cycle.
- A read from an empty FIFO is refused even if a write is accepted in the same cycle. There is no fall-through.
- On wr_acc: mem[w_ptr low bits] ← data_in; w_ptr += 1.
- On rd_acc: data_out ← mem[r_ptr low bits]; r_ptr += 1. data_out holds its value when no read is accepted.
- rd_valid ← rd_acc, registered.
- Simultaneous accepted read and write: count is unchanged. Read and write addresses may be equal only when the FIFO is full. In that case the read returns the old entry, and the write replaces that slot after the read.
- Pointers wrap naturally through 2**(ADDR_W+1).
- full, empty, almost_full, almost_empty and count are combinational from the registered pointers only. They do not depend on w_en or r_en.

## Timing
- Reset (rst low, asynchronous): w_ptr = r_ptr = 0, data_out = 0, rd_valid = 0, overflow = underflow = 0.
- Reset outputs: empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = (AF_THRESH == 0), i.e. 0 for legal values.
- Reset mid-operation discards all contents immediately. Release is synchronous in effect: the first edge with rst high may accept an operation.
- Write latency: data written at edge N is readable by a read requested in cycle N+1 and appears on data_out after edge N+1. Minimum write-to-data_out latency is 2 edges.
- Read latency: 1 edge from rd_acc to data_out/rd_valid.
- Flags and count reflect an accepted operation immediately after the edge that performs it.
- full asserts after the edge accepting the DEPTH-th outstanding write. empty asserts after the edge accepting the last read.

## Configuration
- FIFO_ERR_FLAGS_EN defined:
  - overflow ← 1 on any cycle with w_en & ~wr_acc.
  - underflow ← 1 on any cycle with r_en & ~rd_acc.
  - Both flags clear on an edge with err_clr = 1. A set in the same cycle wins over err_clr.
- FIFO_ERR_FLAGS_EN undefined: overflow and underflow are tied to 0 and err_clr is ignored. Ports remain present.

## Test plan
- Reset, then 32 writes of 0x00..0x1F with defaults -> full = 1 and count = 32 after the 32nd edge; almost_full first seen with count = 28. Then 32 reads -> data_out = 0x00..0x1F in order, each with rd_valid one cycle after r_en; empty = 1 at the end.
- FIFO full, w_en = r_en = 1 with data_in = 0xAA -> both accepted, count stays 32, data_out = the oldest entry, overflow stays 0. 0xAA is read 32 reads later.
- Empty FIFO, w_en = r_en = 1 with data_in = 0x55 -> write accepted, read refused, rd_valid = 0, count = 1. With the macro, underflow = 1.
- With the macro: write while full and no read -> overflow = 1 and count unchanged. err_clr pulse -> overflow = 0. err_clr together with a refused write -> overflow stays 1.
- Assert rst low mid-stream at count = 17 -> all outputs take their reset values asynchronously, before the next clock edge. After release, the first write is read back correctly.
- ADDR_W = 2, DATA_W = 16, AF_THRESH = 3, AE_THRESH = 1, with more than 3 wraps of random traffic -> data_out matches a scoreboard and count matches the model every cycle.
